// File: rtl/mem_wb_stage_pkg.sv
// Shared definitions for the MEM stage: width defaults, data-memory FSM
// state encoding and the branch-decode helper.
package mem_wb_stage_pkg;

    localparam int DATA_W_DEF  = 32;
    localparam int REG_W_DEF   = 5;
    localparam int TIMEOUT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WAIT  = 2'd1,
        ST_ABORT = 2'd2
    } dmem_state_e;

    // beq is taken on zero, bne on non-zero.
    function automatic logic branch_taken(input logic beq, input logic bne, input logic zero);
        return (beq & zero) | (bne & ~zero);
    endfunction

endpackage

// File: rtl/mem_wb_stage_if.sv
// Data-memory bus between the MEM stage (master) and the data memory (slave).
interface mem_wb_stage_if
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) ();

    logic              req;
    logic              we;
    logic [DATA_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [DATA_W-1:0] rdata;
    logic              ack;

    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);

endinterface

// File: rtl/mem_wb_stage_dmem_access_fsm.sv
// Data-memory access controller: tracks an outstanding request, counts wait
// cycles, aborts after TIMEOUT and raises a sticky error flag.
module dmem_access_fsm
    import mem_wb_stage_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic clk,
    input  logic rst_n,
    input  logic memop_i,
    input  logic ack_i,
    output logic req_o,
    output logic stall_o,
    output logic abort_o,
    output logic err_o
);

    localparam int                CNT_W    = $clog2(TIMEOUT);
    localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(TIMEOUT - 1);

    dmem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              err_q, err_d;

    // The aborted entry is released for exactly one cycle with no request.
    assign abort_o = (state_q == ST_ABORT);
    assign req_o   = memop_i & ~abort_o;
    assign stall_o = memop_i & ~ack_i & ~abort_o;
    assign err_o   = err_q;

    // State, wait counter and sticky error register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // Next-state: zero-wait accesses never leave IDLE.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                if (memop_i && !ack_i) begin
                    state_d = ST_WAIT;
                    cnt_d   = CNT_W'(1);
                end
            end
            ST_WAIT: begin
                if (ack_i) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = ST_ABORT;
                    err_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ABORT: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

endmodule

// File: rtl/mem_wb_stage.sv
// MEM stage: EX/MEM latch, data-memory access, branch resolution and the
// MEM/WB latch feeding register-file write-back.
module mem_wb_stage
    import mem_wb_stage_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int REG_W   = REG_W_DEF,
    parameter int TIMEOUT = TIMEOUT_DEF
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ex_valid,
    input  logic               ex_memtoreg,
    input  logic               ex_regwrite,
    input  logic               ex_memwrite,
    input  logic               ex_memread,
    input  logic               ex_branch,
    input  logic               ex_bne,
    input  logic [DATA_W-1:0]  ex_aluout,
    input  logic               ex_zero,
    input  logic [DATA_W-1:0]  ex_addresult,
    input  logic [DATA_W-1:0]  ex_b,
    input  logic [REG_W-1:0]   ex_rd,
    mem_wb_stage_if.master     dmem,
    output logic               stall,
    output logic               pcsrc,
    output logic [DATA_W-1:0]  branch_target,
    output logic               dmem_err,
    output logic               wb_valid,
    output logic               wb_memtoreg,
    output logic               wb_regwrite,
    output logic [DATA_W-1:0]  wb_readdata,
    output logic [DATA_W-1:0]  wb_aluout,
    output logic [REG_W-1:0]   wb_rd
);

    logic              m_valid_q;
    logic              m_memtoreg_q, m_regwrite_q, m_memwrite_q, m_memread_q;
    logic              m_branch_q, m_bne_q, m_zero_q;
    logic [DATA_W-1:0] m_aluout_q, m_addresult_q, m_b_q;
    logic [REG_W-1:0]  m_rd_q;

    logic memop, fsm_req, fsm_stall, fsm_abort, fsm_err;

    assign memop         = m_valid_q & (m_memread_q | m_memwrite_q);
    assign pcsrc         = m_valid_q & branch_taken(m_branch_q, m_bne_q, m_zero_q);
    assign branch_target = m_addresult_q;
    assign stall         = fsm_stall;
    assign dmem_err      = fsm_err;

    assign dmem.req   = fsm_req;
    assign dmem.we    = m_memwrite_q;
    assign dmem.addr  = m_aluout_q;
    assign dmem.wdata = m_b_q;

    dmem_access_fsm #(
        .TIMEOUT (TIMEOUT)
    ) u_fsm (
        .clk     (clk),
        .rst_n   (rst_n),
        .memop_i (memop),
        .ack_i   (dmem.ack),
        .req_o   (fsm_req),
        .stall_o (fsm_stall),
        .abort_o (fsm_abort),
        .err_o   (fsm_err)
    );

    // EX/MEM valid: a taken branch kills the wrong-path entry behind it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_valid_q <= 1'b0;
        end else if (!fsm_stall) begin
            m_valid_q <= ex_valid & ~pcsrc;
        end
    end

    // EX/MEM payload: only meaningful when m_valid_q is set.
    always_ff @(posedge clk) begin
        if (!fsm_stall) begin
            m_memtoreg_q  <= ex_memtoreg;
            m_regwrite_q  <= ex_regwrite;
            m_memwrite_q  <= ex_memwrite;
            m_memread_q   <= ex_memread;
            m_branch_q    <= ex_branch;
            m_bne_q       <= ex_bne;
            m_zero_q      <= ex_zero;
            m_aluout_q    <= ex_aluout;
            m_addresult_q <= ex_addresult;
            m_b_q         <= ex_b;
            m_rd_q        <= ex_rd;
        end
    end

    // MEM/WB latch: bubble while waiting on memory or when the access aborts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
            wb_memtoreg <= 1'b0;
            wb_readdata <= '0;
            wb_aluout   <= '0;
            wb_rd       <= '0;
        end else if (fsm_stall || fsm_abort) begin
            wb_valid    <= 1'b0;
            wb_regwrite <= 1'b0;
        end else begin
            wb_valid    <= m_valid_q;
            wb_regwrite <= m_valid_q & m_regwrite_q;
            wb_memtoreg <= m_memtoreg_q;
            wb_aluout   <= m_aluout_q;
            wb_rd       <= m_rd_q;
            if (m_valid_q && m_memread_q && dmem.ack) begin
                wb_readdata <= dmem.rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_wb_stage.sv
// Bench for mem_wb_stage: table of single-entry vectors plus hand-written
// multi-cycle sequences; write-back results are checked from a scoreboard.
module tb_mem_wb_stage;
    import mem_wb_stage_pkg::*;

    localparam int DATA_W  = 32;
    localparam int REG_W   = 5;
    localparam int TIMEOUT = 16;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              ex_valid = 0, ex_memtoreg = 0, ex_regwrite = 0, ex_memwrite = 0;
    logic              ex_memread = 0, ex_branch = 0, ex_bne = 0, ex_zero = 0;
    logic [DATA_W-1:0] ex_aluout = '0, ex_addresult = '0, ex_b = '0;
    logic [REG_W-1:0]  ex_rd = '0;
    logic              stall, pcsrc, dmem_err;
    logic [DATA_W-1:0] branch_target;
    logic              wb_valid, wb_memtoreg, wb_regwrite;
    logic [DATA_W-1:0] wb_readdata, wb_aluout;
    logic [REG_W-1:0]  wb_rd;

    always #5 clk = ~clk;

    mem_wb_stage_if #(.DATA_W(DATA_W)) dmem_bus ();

    mem_wb_stage #(.DATA_W(DATA_W), .REG_W(REG_W), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .ex_valid(ex_valid), .ex_memtoreg(ex_memtoreg), .ex_regwrite(ex_regwrite),
        .ex_memwrite(ex_memwrite), .ex_memread(ex_memread), .ex_branch(ex_branch),
        .ex_bne(ex_bne), .ex_aluout(ex_aluout), .ex_zero(ex_zero),
        .ex_addresult(ex_addresult), .ex_b(ex_b), .ex_rd(ex_rd),
        .dmem(dmem_bus),
        .stall(stall), .pcsrc(pcsrc), .branch_target(branch_target), .dmem_err(dmem_err),
        .wb_valid(wb_valid), .wb_memtoreg(wb_memtoreg), .wb_regwrite(wb_regwrite),
        .wb_readdata(wb_readdata), .wb_aluout(wb_aluout), .wb_rd(wb_rd)
    );

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    // Scoreboard of expected write-back entries.
    typedef struct {
        logic              regwrite;
        logic              memtoreg;
        logic [DATA_W-1:0] aluout;
        logic [REG_W-1:0]  rd;
        logic              chk_rdata;
        logic [DATA_W-1:0] rdata;
    } wb_exp_t;

    wb_exp_t sb_q[$];
    wb_exp_t mon_e;

    task automatic push_exp(input logic rw, input logic mtr, input logic [DATA_W-1:0] alu,
                            input logic [REG_W-1:0] rd, input logic crd, input logic [DATA_W-1:0] rdata);
        wb_exp_t e;
        e.regwrite = rw; e.memtoreg = mtr; e.aluout = alu; e.rd = rd;
        e.chk_rdata = crd; e.rdata = rdata;
        sb_q.push_back(e);
    endtask

    always @(negedge clk) begin
        if (rst_n && wb_valid) begin
            if (sb_q.size() == 0) begin
                n_chk++;
                $display("FAIL wb_unexpected: got wb_valid=1 rd=%0d aluout=0x%0h, want no write-back", wb_rd, wb_aluout);
            end else begin
                mon_e = sb_q.pop_front();
                chk("wb_regwrite", 32'(wb_regwrite), 32'(mon_e.regwrite));
                chk("wb_memtoreg", 32'(wb_memtoreg), 32'(mon_e.memtoreg));
                chk("wb_aluout",   wb_aluout,        mon_e.aluout);
                chk("wb_rd",       32'(wb_rd),       32'(mon_e.rd));
                if (mon_e.chk_rdata) chk("wb_readdata", wb_readdata, mon_e.rdata);
            end
        end
    end

    // Single-entry vectors: fields in order valid, memtoreg, regwrite, memwrite,
    // memread, branch, bne, zero, aluout, addresult, b, rdata, rd, exp_pcsrc, exp_wb.
    typedef struct {
        logic              valid, memtoreg, regwrite, memwrite, memread, branch, bne, zero;
        logic [DATA_W-1:0] aluout, addres, b, rdata;
        logic [REG_W-1:0]  rd;
        logic              exp_pcsrc, exp_wb;
    } vec_t;

    vec_t vecs[9];

    task automatic drive_vec(input vec_t v);
        ex_valid = v.valid; ex_memtoreg = v.memtoreg; ex_regwrite = v.regwrite;
        ex_memwrite = v.memwrite; ex_memread = v.memread; ex_branch = v.branch;
        ex_bne = v.bne; ex_zero = v.zero; ex_aluout = v.aluout;
        ex_addresult = v.addres; ex_b = v.b; ex_rd = v.rd;
    endtask

    task automatic alu_op(input logic [DATA_W-1:0] alu, input logic [REG_W-1:0] rd);
        @(negedge clk);
        ex_valid = 1; ex_memtoreg = 0; ex_regwrite = 1; ex_memwrite = 0; ex_memread = 0;
        ex_branch = 0; ex_bne = 0; ex_zero = 0; ex_aluout = alu; ex_rd = rd;
        push_exp(1'b1, 1'b0, alu, rd, 1'b0, '0);
        @(posedge clk); #1;
        ex_valid = 0;
        @(posedge clk); #1;
        chk("alu_op_latency_wb_valid", 32'(wb_valid), 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    int nreq, nstall, nst;

    initial begin
        vecs[0] = '{1,0,1,0,0,0,0,0, 32'h2A,  32'h0,   32'h0,  32'h0,        5'd5, 0, 1};
        vecs[1] = '{1,0,1,0,0,0,0,1, 32'h13,  32'h0,   32'h0,  32'h0,        5'd0, 0, 1};
        vecs[2] = '{1,0,0,0,0,1,0,0, 32'h5,   32'h200, 32'h0,  32'h0,        5'd0, 0, 1};
        vecs[3] = '{1,0,0,0,0,0,1,1, 32'h0,   32'h280, 32'h0,  32'h0,        5'd0, 0, 1};
        vecs[4] = '{1,0,0,0,0,0,1,0, 32'h7,   32'h300, 32'h0,  32'h0,        5'd0, 1, 1};
        vecs[5] = '{1,1,1,0,1,0,0,0, 32'h44,  32'h0,   32'h0,  32'hCAFEF00D, 5'd3, 0, 1};
        vecs[6] = '{1,0,1,1,0,0,0,0, 32'h48,  32'h0,   32'h55, 32'h0,        5'd0, 0, 1};
        vecs[7] = '{0,1,1,0,1,0,0,0, 32'h4C,  32'h0,   32'h0,  32'h12345678, 5'd8, 0, 0};
        vecs[8] = '{1,0,0,0,0,0,0,0, 32'h99,  32'h0,   32'h0,  32'h0,        5'd6, 0, 1};

        dmem_bus.ack = 0;
        dmem_bus.rdata = '0;
        rst_n = 0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_wb_valid",    32'(wb_valid),     32'd0);
        chk("rst_wb_regwrite", 32'(wb_regwrite),  32'd0);
        chk("rst_stall",       32'(stall),        32'd0);
        chk("rst_pcsrc",       32'(pcsrc),        32'd0);
        chk("rst_dmem_err",    32'(dmem_err),     32'd0);
        chk("rst_dmem_req",    32'(dmem_bus.req), 32'd0);
        @(negedge clk);
        rst_n = 1;

        // Table: each entry alone, memory ops acknowledged in the same cycle.
        for (int i = 0; i < 9; i++) begin
            @(negedge clk);
            drive_vec(vecs[i]);
            dmem_bus.ack   = vecs[i].memread | vecs[i].memwrite;
            dmem_bus.rdata = vecs[i].rdata;
            if (vecs[i].exp_wb)
                push_exp(vecs[i].regwrite, vecs[i].memtoreg, vecs[i].aluout, vecs[i].rd,
                         vecs[i].memread, vecs[i].rdata);
            @(posedge clk); #1;
            chk($sformatf("v%0d_pcsrc", i), 32'(pcsrc), 32'(vecs[i].exp_pcsrc));
            if (vecs[i].exp_pcsrc)
                chk($sformatf("v%0d_branch_target", i), branch_target, vecs[i].addres);
            chk($sformatf("v%0d_stall", i), 32'(stall), 32'd0);
            chk($sformatf("v%0d_dmem_req", i), 32'(dmem_bus.req),
                32'(vecs[i].valid & (vecs[i].memread | vecs[i].memwrite)));
            ex_valid = 0;
            @(posedge clk); #1;
            chk($sformatf("v%0d_wb_valid", i), 32'(wb_valid), 32'(vecs[i].exp_wb));
            dmem_bus.ack = 0;
        end

        // Load acknowledged in the fourth request cycle.
        @(negedge clk);
        ex_valid = 1; ex_memread = 1; ex_memwrite = 0; ex_memtoreg = 1; ex_regwrite = 1;
        ex_branch = 0; ex_bne = 0; ex_aluout = 32'h40; ex_rd = 5'd7;
        dmem_bus.ack = 0;
        push_exp(1'b1, 1'b1, 32'h40, 5'd7, 1'b1, 32'hDEADBEEF);
        @(posedge clk); #1;
        chk("load_addr", dmem_bus.addr, 32'h40);
        chk("load_we",   32'(dmem_bus.we), 32'd0);
        ex_valid = 0;
        nreq = 0; nstall = 0;
        for (int c = 0; c < 4; c++) begin
            if (c == 3) begin
                dmem_bus.ack = 1;
                dmem_bus.rdata = 32'hDEADBEEF;
            end
            #1;
            if (dmem_bus.req) nreq++;
            if (stall) nstall++;
            @(posedge clk); #1;
        end
        dmem_bus.ack = 0;
        chk("load_req_cycles",   32'(nreq),   32'd4);
        chk("load_stall_cycles", 32'(nstall), 32'd3);
        chk("load_wb_valid",     32'(wb_valid), 32'd1);
        chk("load_req_after",    32'(dmem_bus.req), 32'd0);

        // Taken beq kills the entry right behind it.
        @(negedge clk);
        ex_valid = 1; ex_memread = 0; ex_memwrite = 0; ex_memtoreg = 0; ex_regwrite = 0;
        ex_branch = 1; ex_zero = 1; ex_addresult = 32'h100; ex_aluout = 32'h0; ex_rd = 5'd0;
        push_exp(1'b0, 1'b0, 32'h0, 5'd0, 1'b0, '0);
        @(posedge clk); #1;
        chk("beq_pcsrc",  32'(pcsrc), 32'd1);
        chk("beq_target", branch_target, 32'h100);
        ex_branch = 0; ex_zero = 0; ex_regwrite = 1; ex_aluout = 32'h77; ex_rd = 5'd9;
        @(posedge clk); #1;
        chk("beq_pcsrc_one_cycle", 32'(pcsrc), 32'd0);
        ex_valid = 0;
        @(posedge clk); #1;
        chk("beq_killed_wb_valid", 32'(wb_valid), 32'd0);

        // Store never acknowledged: times out, aborts and raises the error flag.
        @(negedge clk);
        ex_valid = 1; ex_memwrite = 1; ex_memread = 0; ex_regwrite = 0; ex_memtoreg = 0;
        ex_aluout = 32'h80; ex_b = 32'h1234; ex_rd = 5'd2;
        @(posedge clk); #1;
        chk("store_we",    32'(dmem_bus.we), 32'd1);
        chk("store_addr",  dmem_bus.addr,    32'h80);
        chk("store_wdata", dmem_bus.wdata,   32'h1234);
        ex_valid = 0; ex_memwrite = 0;
        nst = 0;
        while (stall && nst < 4 * TIMEOUT) begin
            nst++;
            @(posedge clk); #1;
        end
        // One IDLE cycle plus TIMEOUT-1 WAIT cycles (count 1..TIMEOUT-1).
        chk("timeout_stall_cycles", 32'(nst), 32'(TIMEOUT));
        chk("abort_req",      32'(dmem_bus.req), 32'd0);
        chk("abort_dmem_err", 32'(dmem_err),     32'd1);
        @(posedge clk); #1;
        chk("abort_wb_valid", 32'(wb_valid), 32'd0);
        alu_op(32'h99, 5'd12);
        chk("dmem_err_sticky", 32'(dmem_err), 32'd1);

        // Asynchronous reset while a load waits for its acknowledge.
        @(negedge clk);
        ex_valid = 1; ex_memread = 1; ex_memtoreg = 1; ex_regwrite = 1;
        ex_aluout = 32'h60; ex_rd = 5'd4;
        @(posedge clk); #1;
        ex_valid = 0; ex_memread = 0;
        repeat (2) @(posedge clk);
        #2;
        chk("pre_reset_req", 32'(dmem_bus.req), 32'd1);
        rst_n = 0;
        #1;
        chk("midrst_req",      32'(dmem_bus.req), 32'd0);
        chk("midrst_stall",    32'(stall),        32'd0);
        chk("midrst_wb_valid", 32'(wb_valid),     32'd0);
        chk("midrst_dmem_err", 32'(dmem_err),     32'd0);
        @(negedge clk);
        rst_n = 1;
        @(posedge clk); #1;
        chk("post_rst_fsm_idle", 32'(dut.u_fsm.state_q), 32'(ST_IDLE));
        alu_op(32'h2B, 5'd10);

        repeat (3) @(posedge clk);
        #1;
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
